// File: rtl/core_pkg.sv
// Shared RV32I control definitions: ALU operation and immediate format enums,
// opcode constants and the datapath mux select encodings.
// Ports: none (package).
package core_pkg;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLT,
      ALU_SLTU,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_SRC1,
      ALU_SRC2
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] SRC1_PC     = 2'd0;
   localparam logic [1:0] SRC1_PC_OLD = 2'd1;
   localparam logic [1:0] SRC1_RS1    = 2'd2;

   localparam logic [1:0] SRC2_RS2    = 2'd0;
   localparam logic [1:0] SRC2_IMM    = 2'd1;
   localparam logic [1:0] SRC2_FOUR   = 2'd2;

   localparam logic [1:0] RES_ALU_OUT    = 2'd0;
   localparam logic [1:0] RES_MEM        = 2'd1;
   localparam logic [1:0] RES_ALU_RESULT = 2'd2;

   // Compare operation used by a branch: equality tests subtract, the
   // signed/unsigned ordering tests use the set-less-than ops.
   function automatic alu_ctrl_t branch_alu_op(input logic [2:0] funct3);
      alu_ctrl_t op;
      case (funct3[2:1])
         2'b10:   op = ALU_SLT;
         2'b11:   op = ALU_SLTU;
         default: op = ALU_SUB;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Memory request handshake between the main controller and the memory port.
// mem_req   : request, held until mem_ready
// mem_we    : store qualifier for mem_req
// addr_sel  : address source, 0 = PC, 1 = ALU_out register
// mem_ready : memory completes the current request this cycle
interface control_fsm_if;

   logic mem_req;
   logic mem_we;
   logic addr_sel;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output addr_sel,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  addr_sel,
      output mem_ready
   );

endinterface

// File: rtl/alu_decoder.sv
// ALU operation decode for register and immediate arithmetic instructions.
// funct3   : instruction funct3 field
// funct7b5 : instruction bit 30
// is_r     : 1 for register-register form (enables SUB)
// alu_ctrl : resulting ALU operation
module alu_decoder
   import core_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       is_r,
   output alu_ctrl_t  alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (funct3)
         // Bit 30 of an immediate add is part of the immediate, not SUB.
         3'b000:  alu_ctrl = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_ctrl = ALU_SLL;
         3'b010:  alu_ctrl = ALU_SLT;
         3'b011:  alu_ctrl = ALU_SLTU;
         3'b100:  alu_ctrl = ALU_XOR;
         3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_ctrl = ALU_OR;
         default: alu_ctrl = ALU_AND;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle main controller for the RV32I core. Sequences each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath.
// clk, rst_n      : clock, asynchronous active-low reset
// mem             : memory request handshake (master side)
// instr           : current IR contents
// zero            : ALU equal flag
// ALU_result_lsb  : ALU_result[0], for SLT/SLTU branches
// IR_write, PC_write, reg_write : single-cycle write strobes
// result_sel      : writeback source
// imm_sel         : immediate format
// ALU_src1_sel, ALU_src2_sel, ALU_ctrl : ALU operand selects and operation
// halted          : illegal instruction seen, sticky until reset
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | one cycle after reset (optional PC reload)
// FETCH     | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE    | ALU_out <= PC_old + imm (branch/jump target)
// EXEC_R    | rs1 op rs2
// EXEC_I    | rs1 op imm
// ALU_WB    | rd <= ALU_out
// MEM_ADDR  | ALU_out <= rs1 + imm
// MEM_RD    | load request, wait for mem_ready
// MEM_WB    | rd <= memory data
// MEM_WR    | store request, wait for mem_ready
// BRANCH    | compare rs1/rs2, PC <= target when taken
// JAL       | rd <= PC, PC <= target
// JALR      | ALU_out <= rs1 + imm
// JALR_WB   | rd <= PC, PC <= ALU_out
// LUI       | rd <= imm
// AUIPC     | rd <= PC_old + imm
// HALT      | illegal opcode, terminal until reset
module control_fsm
   import core_pkg::*;
#(
   parameter bit RESET_PC_WRITE = 1'b0
)
(
   input  logic                clk,
   input  logic                rst_n,
   control_fsm_if.master       mem,
   input  logic [31:0]         instr,
   input  logic                zero,
   input  logic                ALU_result_lsb,
   output logic                IR_write,
   output logic                PC_write,
   output logic                reg_write,
   output logic [1:0]          result_sel,
   output imm_fmt_t            imm_sel,
   output logic [1:0]          ALU_src1_sel,
   output logic [1:0]          ALU_src2_sel,
   output alu_ctrl_t           ALU_ctrl,
   output logic                halted
);

   typedef enum logic [4:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALU_WB,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_JALR_WB,
      S_LUI,
      S_AUIPC,
      S_HALT
   } state_t;

   state_t     state_q;
   state_t     state_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       unused_instr;

   alu_ctrl_t  arith_op;
   logic       br_taken;
   logic       br_illegal;

   logic       mem_req_c;
   logic       mem_we_c;
   logic       addr_sel_c;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign funct7b5     = instr[30];
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   alu_decoder u_alu_decoder (
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .is_r     (state_q == S_EXEC_R),
      .alu_ctrl (arith_op)
   );

   // Branch condition; funct3 010/011 have no branch meaning.
   always_comb begin
      br_taken   = 1'b0;
      br_illegal = 1'b0;
      case (funct3)
         3'b000:  br_taken   = zero;
         3'b001:  br_taken   = !zero;
         3'b100:  br_taken   = ALU_result_lsb;
         3'b101:  br_taken   = !ALU_result_lsb;
         3'b110:  br_taken   = ALU_result_lsb;
         3'b111:  br_taken   = !ALU_result_lsb;
         default: br_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     state_d = S_FETCH;
         S_FETCH:    if (mem.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_R:                state_d = S_EXEC_R;
               OP_I:                state_d = S_EXEC_I;
               OP_LOAD, OP_STORE:   state_d = S_MEM_ADDR;
               OP_BRANCH:           state_d = S_BRANCH;
               OP_JAL:              state_d = S_JAL;
               OP_JALR:             state_d = S_JALR;
               OP_LUI:              state_d = S_LUI;
               OP_AUIPC:            state_d = S_AUIPC;
               default:             state_d = S_HALT;
            endcase
         end
         S_EXEC_R,
         S_EXEC_I:   state_d = S_ALU_WB;
         S_MEM_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem.mem_ready) state_d = S_MEM_WB;
         S_MEM_WR:   if (mem.mem_ready) state_d = S_FETCH;
         S_BRANCH:   state_d = br_illegal ? S_HALT : S_FETCH;
         S_JALR:     state_d = S_JALR_WB;
         S_ALU_WB,
         S_MEM_WB,
         S_JAL,
         S_JALR_WB,
         S_LUI,
         S_AUIPC:    state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req_c    = 1'b0;
      mem_we_c     = 1'b0;
      addr_sel_c   = 1'b0;
      IR_write     = 1'b0;
      PC_write     = 1'b0;
      reg_write    = 1'b0;
      result_sel   = RES_ALU_OUT;
      imm_sel      = IMM_I;
      ALU_src1_sel = SRC1_PC;
      ALU_src2_sel = SRC2_FOUR;
      ALU_ctrl     = ALU_ADD;
      halted       = 1'b0;
      case (state_q)
         S_IDLE: PC_write = RESET_PC_WRITE;
         S_FETCH: begin
            mem_req_c = 1'b1;
            IR_write  = mem.mem_ready;
            PC_write  = mem.mem_ready;
         end
         S_DECODE: begin
            // JAL has no later cycle to form its target, so DECODE
            // computes the J-immediate target for it.
            ALU_src1_sel = SRC1_PC_OLD;
            ALU_src2_sel = SRC2_IMM;
            imm_sel      = (opcode == OP_JAL) ? IMM_J : IMM_B;
         end
         S_EXEC_R: begin
            ALU_src1_sel = SRC1_RS1;
            ALU_src2_sel = SRC2_RS2;
            ALU_ctrl     = arith_op;
         end
         S_EXEC_I: begin
            ALU_src1_sel = SRC1_RS1;
            ALU_src2_sel = SRC2_IMM;
            ALU_ctrl     = arith_op;
         end
         S_ALU_WB: reg_write = 1'b1;
         S_MEM_ADDR: begin
            ALU_src1_sel = SRC1_RS1;
            ALU_src2_sel = SRC2_IMM;
            imm_sel      = (opcode == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEM_RD: begin
            mem_req_c  = 1'b1;
            addr_sel_c = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            result_sel = RES_MEM;
         end
         S_MEM_WR: begin
            mem_req_c  = 1'b1;
            mem_we_c   = 1'b1;
            addr_sel_c = 1'b1;
         end
         S_BRANCH: begin
            ALU_src1_sel = SRC1_RS1;
            ALU_src2_sel = SRC2_RS2;
            ALU_ctrl     = branch_alu_op(funct3);
            PC_write     = br_taken && !br_illegal;
         end
         S_JAL,
         S_JALR_WB: begin
            ALU_ctrl   = ALU_SRC1;
            result_sel = RES_ALU_RESULT;
            reg_write  = 1'b1;
            PC_write   = 1'b1;
         end
         S_JALR: begin
            ALU_src1_sel = SRC1_RS1;
            ALU_src2_sel = SRC2_IMM;
         end
         S_LUI: begin
            ALU_src2_sel = SRC2_IMM;
            ALU_ctrl     = ALU_SRC2;
            imm_sel      = IMM_U;
            result_sel   = RES_ALU_RESULT;
            reg_write    = 1'b1;
         end
         S_AUIPC: begin
            ALU_src1_sel = SRC1_PC_OLD;
            ALU_src2_sel = SRC2_IMM;
            imm_sel      = IMM_U;
            result_sel   = RES_ALU_RESULT;
            reg_write    = 1'b1;
         end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   assign mem.mem_req  = mem_req_c;
   assign mem.mem_we   = mem_we_c;
   assign mem.addr_sel = addr_sel_c;

endmodule
